// File: rtl/gpr_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpr_dump_pkg
//  Purpose  : Shared types and default sizes for the GPR dump reader.
//  Revision : 1.0 - initial release
// ============================================================================
package gpr_dump_pkg;

  // Default register file geometry (RV32 integer file)
  localparam int c_NREGS_DEFAULT = 32;
  localparam int c_AW_DEFAULT    = 5;
  localparam int c_XLEN_DEFAULT  = 32;

  // Dump sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dumpState_t;

  // Index of the first register emitted by a dump
  function automatic int firstIndex(input int skipX0);
    return (skipX0 != 0) ? 1 : 0;
  endfunction

endpackage : gpr_dump_pkg
`default_nettype wire

// File: rtl/gpr_dump.sv
`default_nettype none
// ============================================================================
//  Module   : gpr_dump
//  Purpose  : Walks register file read port 1 in ascending order and streams
//             each {index, value} pair over a valid/ready interface. Stalls
//             the core for the whole dump so the captured values form one
//             consistent snapshot.
//  Revision : 1.0 - initial release
// ============================================================================
module gpr_dump
  import gpr_dump_pkg::*;
#(
  parameter int NREGS   = c_NREGS_DEFAULT,
  parameter int AW      = c_AW_DEFAULT,
  parameter int XLEN    = c_XLEN_DEFAULT,
  parameter int SKIP_X0 = 0
) (
  input  logic            WrClk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [AW-1:0]   Ra,
  input  logic [XLEN-1:0] busA,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_idx,
  output logic [XLEN-1:0] out_data
);

  localparam logic [AW-1:0] c_FIRST_IDX = AW'(firstIndex(SKIP_X0));
  localparam logic [AW-1:0] c_LAST_IDX  = AW'(NREGS - 1);

  dumpState_t      r_state;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   r_ra;
  logic            r_outValid;
  logic [AW-1:0]   r_outIdx;
  logic [XLEN-1:0] r_outData;
  logic            r_done;

  logic            w_handshake;
  logic            w_lastBeat;
  logic [AW-1:0]   w_nextIdx;

  // Beat accepted by the sink; only meaningful while a beat is on offer
  assign w_handshake = r_outValid & out_ready;
  assign w_lastBeat  = (r_idx == c_LAST_IDX);
  assign w_nextIdx   = r_idx + AW'(1);

  // Dump sequencer: index counter, read address, captured beat and done pulse
  always_ff @(posedge WrClk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_ra       <= '0;
      r_outValid <= 1'b0;
      r_outIdx   <= '0;
      r_outData  <= '0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done     <= 1'b0;
          r_outValid <= 1'b0;
          if (start) begin
            r_idx   <= c_FIRST_IDX;
            r_ra    <= c_FIRST_IDX;
            r_state <= READ;
          end
        end

        READ: begin
          // Register file read is combinational: capture busA this cycle
          r_outData  <= busA;
          r_outIdx   <= r_idx;
          r_outValid <= 1'b1;
          r_ra       <= '0;
          r_state    <= SEND;
        end

        SEND: begin
          // Beat held stable until the sink takes it
          if (w_handshake) begin
            r_outValid <= 1'b0;
            if (w_lastBeat) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_idx   <= w_nextIdx;
              r_ra    <= w_nextIdx;
              r_state <= READ;
            end
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state    <= IDLE;
          r_outValid <= 1'b0;
          r_done     <= 1'b0;
          r_ra       <= '0;
        end
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign stall     = busy;
  assign done      = r_done;
  assign Ra        = r_ra;
  assign out_valid = r_outValid;
  assign out_idx   = r_outIdx;
  assign out_data  = r_outData;

endmodule : gpr_dump
`default_nettype wire

// File: tb/tb_gpr_dump.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpr_dump
//  Purpose  : Self-checking bench for gpr_dump. Two instances (x0 emitted and
//             x0 skipped) share stimulus; a per-cycle model predicts every
//             output from the dump rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_dump;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int XLEN  = 32;

  logic            WrClk;
  logic            rst;
  logic            start;
  logic            out_ready;

  logic            busy0, done0, stall0, valid0;
  logic [AW-1:0]   ra0, idx0;
  logic [XLEN-1:0] busA0, data0;
  logic            busy1, done1, stall1, valid1;
  logic [AW-1:0]   ra1, idx1;
  logic [XLEN-1:0] busA1, data1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit armed  = 0;

  // Model state per instance: 0 idle, 1 fetching, 2 offering, 3 finishing
  int phase[2];
  int cur[2];
  int beats[2];
  int lastIdx[2];
  int startCyc[2];
  int firstValidCyc[2];
  int doneCyc[2];
  int doneCount[2];
  int firstIdx[2];
  logic [XLEN-1:0] firstData[2];

  // Register file contents: x0 = 0, xi = 0x1000 + i
  function automatic logic [XLEN-1:0] regVal(input int i);
    return (i == 0) ? '0 : XLEN'(32'h1000 + i);
  endfunction

  assign busA0 = regVal(int'(ra0));
  assign busA1 = regVal(int'(ra1));

  initial WrClk = 1'b0;
  always #5 WrClk = ~WrClk;

  gpr_dump #(.NREGS(NREGS), .AW(AW), .XLEN(XLEN), .SKIP_X0(0)) dut0 (
    .WrClk(WrClk), .rst(rst), .start(start), .busy(busy0), .done(done0),
    .stall(stall0), .Ra(ra0), .busA(busA0), .out_valid(valid0),
    .out_ready(out_ready), .out_idx(idx0), .out_data(data0)
  );

  gpr_dump #(.NREGS(NREGS), .AW(AW), .XLEN(XLEN), .SKIP_X0(1)) dut1 (
    .WrClk(WrClk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .stall(stall1), .Ra(ra1), .busA(busA1), .out_valid(valid1),
    .out_ready(out_ready), .out_idx(idx1), .out_data(data1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare one instance against the model for the current cycle
  task automatic checkDut(input int k, input logic b, input logic d, input logic s,
                          input logic v, input logic [AW-1:0] ra,
                          input logic [AW-1:0] oi, input logic [XLEN-1:0] od);
    string tag;
    tag = (k == 0) ? "d0" : "d1";
    chk({tag, ".busy"},      32'(b),  32'(phase[k] != 0));
    chk({tag, ".stall"},     32'(s),  32'(phase[k] != 0));
    chk({tag, ".done"},      32'(d),  32'(phase[k] == 3));
    chk({tag, ".out_valid"}, 32'(v),  32'(phase[k] == 2));
    chk({tag, ".Ra"},        32'(ra), (phase[k] == 1) ? 32'(cur[k]) : 32'd0);
    if (phase[k] == 2) begin
      chk({tag, ".out_idx"},  32'(oi), 32'(cur[k]));
      chk({tag, ".out_data"}, 32'(od), regVal(cur[k]));
      if (firstValidCyc[k] < 0) begin
        firstValidCyc[k] = cyc;
        firstIdx[k]      = int'(oi);
        firstData[k]     = od;
      end
    end
    if (phase[k] == 3) begin
      doneCyc[k] = cyc;
      doneCount[k]++;
      chk({tag, ".beats_at_done"}, 32'(beats[k]), 32'(NREGS - k));
    end
  endtask

  // Advance the model across the coming clock edge using the driven inputs
  task automatic advance(input int k);
    if (rst) begin
      phase[k] = 0;
    end else begin
      case (phase[k])
        0: if (start) begin
             phase[k] = 1; cur[k] = k; beats[k] = 0;
             startCyc[k] = cyc; firstValidCyc[k] = -1;
           end
        1: phase[k] = 2;
        2: if (out_ready) begin
             beats[k]++; lastIdx[k] = cur[k];
             if (cur[k] == NREGS - 1) phase[k] = 3;
             else begin cur[k]++; phase[k] = 1; end
           end
        default: phase[k] = 0;
      endcase
    end
  endtask

  // Per-cycle compare, sampled on the falling edge
  initial begin
    for (int k = 0; k < 2; k++) begin
      phase[k] = 0; cur[k] = 0; beats[k] = 0; lastIdx[k] = -1; doneCount[k] = 0;
      startCyc[k] = 0; firstValidCyc[k] = -1; doneCyc[k] = 0; firstIdx[k] = -1;
      firstData[k] = '0;
    end
    forever begin
      @(negedge WrClk);
      cyc++;
      if (armed) begin
        checkDut(0, busy0, done0, stall0, valid0, ra0, idx0, data0);
        checkDut(1, busy1, done1, stall1, valid1, ra1, idx1, data1);
      end
      if (rst) armed = 1;
      advance(0);
      advance(1);
    end
  end

  task automatic tick();
    @(posedge WrClk);
    #2;
  endtask

  task automatic waitBeat(input int idx);
    int n;
    n = 0;
    while (!(valid0 === 1'b1 && int'(idx0) == idx) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL wait_beat_%0d: beat never offered within 400 cycles", idx);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy0 !== 1'b0 || busy1 !== 1'b0) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL wait_idle: dump still busy after 400 cycles");
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int dc0;
    int dc1;
    rst = 1'b1; start = 1'b1; out_ready = 1'b1;

    // T1: reset, with start held during reset
    tick(); tick();
    rst = 1'b0; start = 1'b0;
    tick();
    chk("t1.busy",     32'(busy0), 32'd0);
    chk("t1.out_idx",  32'(idx0),  32'd0);
    chk("t1.out_data", data0,      32'd0);
    chk("t1.Ra",       32'(ra0),   32'd0);

    // T2 + T4: full dumps with sink always ready
    dc0 = doneCount[0]; dc1 = doneCount[1];
    pulseStart();
    waitIdle();
    tick();
    chk("t2.first_valid_latency", 32'(firstValidCyc[0] - startCyc[0]), 32'd2);
    chk("t2.done_latency",        32'(doneCyc[0] - startCyc[0]),       32'd65);
    chk("t2.beats",               32'(beats[0]),   32'd32);
    chk("t2.first_idx",           32'(firstIdx[0]), 32'd0);
    chk("t2.first_data",          firstData[0],     32'd0);
    chk("t2.last_idx",            32'(lastIdx[0]),  32'd31);
    chk("t2.done_pulses",         32'(doneCount[0] - dc0), 32'd1);
    chk("t4.beats",               32'(beats[1]),    32'd31);
    chk("t4.first_idx",           32'(firstIdx[1]), 32'd1);
    chk("t4.first_data",          firstData[1],     32'h1001);
    chk("t4.last_idx",            32'(lastIdx[1]),  32'd31);
    chk("t4.done_pulses",         32'(doneCount[1] - dc1), 32'd1);

    // T3: backpressure on beat 7
    pulseStart();
    waitBeat(7);
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("t3.held_idx",  32'(idx0), 32'd7);
      chk("t3.held_data", data0,     32'h1007);
      chk("t3.stall",     32'(stall0), 32'd1);
    end
    out_ready = 1'b1;
    waitIdle();
    tick();
    chk("t3.beats", 32'(beats[0]), 32'd32);

    // T5: reset in the middle of a dump, then restart
    dc0 = doneCount[0];
    pulseStart();
    waitBeat(12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5.valid_after_rst", 32'(valid0), 32'd0);
    chk("t5.busy_after_rst",  32'(busy0),  32'd0);
    tick(); tick();
    chk("t5.no_done", 32'(doneCount[0] - dc0), 32'd0);
    pulseStart();
    waitIdle();
    tick();
    chk("t5.restart_first_idx", 32'(firstIdx[0]), 32'd0);
    chk("t5.restart_beats",     32'(beats[0]),    32'd32);

    // T6: start pulses while busy are ignored
    dc0 = doneCount[0];
    pulseStart();
    waitBeat(3);
    pulseStart();
    waitBeat(20);
    pulseStart();
    waitIdle();
    repeat (4) tick();
    chk("t6.done_pulses", 32'(doneCount[0] - dc0), 32'd1);
    chk("t6.beats",       32'(beats[0]),           32'd32);
    chk("t6.idle",        32'(busy0),              32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gpr_dump
`default_nettype wire
